// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for masked gadgets: a 128-bit LFSR that is seeded with four
// 32-bit words, discards WARM advances, then serves RND_W bits per consumer handshake.
module msk_rnd_source #(
   parameter int RND_W = 4,
   parameter int WARM  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      seed_in,
   input  logic             seed_valid,
   output logic             seed_ready,
   output logic [RND_W-1:0] rnd,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // a seed transfer in RUN takes priority over a randomness transfer in the same cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      WARMUP = 2'd2,
      RUN    = 2'd3
   } state_t;

   localparam logic [7:0] WARM_LD = 8'(WARM);

   state_t         state;
   logic [127:0]   s;
   logic [1:0]     word_cnt;
   logic [7:0]     warm_cnt;
   logic           accept;
   logic [127:0]   s_shift;
   logic [127:0]   s_adv;

   // RND_W LFSR steps unrolled into one combinational advance.
   function automatic logic [127:0] advance(input logic [127:0] v);
      logic [127:0] t;
      t = v;
      for (int i = 0; i < RND_W; i++) begin
         t = {t[126:0], t[127] ^ t[125] ^ t[100] ^ t[98]};
      end
      return t;
   endfunction

   assign accept  = seed_valid & seed_ready;
   assign s_shift = {s[95:0], seed_in};
   assign s_adv   = advance(s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         s        <= '0;
         word_cnt <= '0;
         warm_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  s        <= s_shift;
                  word_cnt <= 2'd1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (word_cnt == 2'd3) begin
                     // An all-zero state would lock the LFSR forever.
                     s        <= (s_shift == '0) ? 128'h1 : s_shift;
                     word_cnt <= '0;
                     warm_cnt <= WARM_LD;
                     state    <= WARMUP;
                  end else begin
                     s        <= s_shift;
                     word_cnt <= word_cnt + 2'd1;
                  end
               end
            end
            WARMUP: begin
               s        <= s_adv;
               warm_cnt <= warm_cnt - 8'd1;
               if (warm_cnt == 8'd1) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  s        <= s_shift;
                  word_cnt <= 2'd1;
                  state    <= LOAD;
               end else if (rnd_ready) begin
                  s <= s_adv;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign seed_ready = (state != WARMUP);
   assign rnd_valid  = (state == RUN);
   assign rnd        = (state == RUN) ? s[RND_W-1:0] : '0;
   assign busy       = (state == LOAD) || (state == WARMUP);
   assign fsm_state  = state;

endmodule

// File: tb/tb_msk_rnd_source.sv
// Scoreboard bench for msk_rnd_source with RND_W=4, WARM=1: directed seeds with
// hand-derived rnd values, hold, reseed collision, zero-seed guard and reset cases.
module tb_msk_rnd_source;

   localparam int RND_W = 4;
   localparam int WARM  = 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      seed_in;
   logic             seed_valid;
   logic             seed_ready;
   logic [RND_W-1:0] rnd;
   logic             rnd_valid;
   logic             rnd_ready;
   logic             busy;
   logic [1:0]       fsm_state;

   int checks   = 0;
   int failures = 0;
   logic sb_en;
   logic [RND_W-1:0] exp_q[$];

   msk_rnd_source #(.RND_W(RND_W), .WARM(WARM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_in    (seed_in),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .rnd        (rnd),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .busy       (busy),
      .fsm_state  (fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout req=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s act=0x%0h req=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   // monitor: a rnd transfer is valid&ready without a competing seed accept
   always @(negedge clk) begin
      if (sb_en && rst_n && rnd_valid && rnd_ready && !(seed_valid && seed_ready)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected act=0x%0h req=none t=%0t", rnd, $time);
         end else begin
            check("sb_rnd", 32'(rnd), 32'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic send_word(input logic [31:0] w);
      int n = 0;
      seed_in    = w;
      seed_valid = 1'b1;
      @(negedge clk);
      while (!seed_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!seed_ready) check("seed_timeout", 32'(seed_ready), 32'd1);
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
   endtask

   task automatic send_seed(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
      send_word(w0);
      send_word(w1);
      send_word(w2);
      send_word(w3);
   endtask

   // counts edges from the word-4 accept until rnd_valid rises
   task automatic wait_valid(input string name);
      int cyc = 0;
      while (!rnd_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check(name, 32'(cyc), 32'(WARM));
   endtask

   task automatic consume(input int n);
      int t;
      rnd_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         t = 0;
         @(negedge clk);
         while (!rnd_valid && t < 20) begin
            t++;
            @(negedge clk);
         end
         if (!rnd_valid) check("consume_timeout", 32'(rnd_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      rnd_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rnd_valid"}, 32'(rnd_valid), 32'd0);
      check({tag, "_rnd"}, 32'(rnd), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_seed_ready"}, 32'(seed_ready), 32'd1);
      check({tag, "_state"}, 32'(fsm_state), 32'd0);
   endtask

   initial begin
      int zrun;
      int zmax;
      rst_n      = 1'b0;
      seed_in    = '0;
      seed_valid = 1'b0;
      rnd_ready  = 1'b0;
      sb_en      = 1'b1;

      // reset state, then 10 idle cycles
      #12;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_rnd_valid", 32'(rnd_valid), 32'd0);
         check("idle_seed_ready", 32'(seed_ready), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1;

      // seed A: first rnd 4, then 0 (S = 0x40), then 0
      send_seed(32'h4000_0000, 32'h0, 32'h0, 32'h0);
      check("a_warm_busy", 32'(busy), 32'd1);
      check("a_warm_seed_ready", 32'(seed_ready), 32'd0);
      check("a_warm_rnd_valid", 32'(rnd_valid), 32'd0);
      check("a_warm_rnd", 32'(rnd), 32'd0);
      wait_valid("a_latency");
      check("a_run_busy", 32'(busy), 32'd0);
      exp_q.push_back(4'h4);
      exp_q.push_back(4'h0);
      exp_q.push_back(4'h0);
      consume(3);

      // seed B: warmup leaves S = 0x3; hold five cycles, then one accept gives 0
      send_seed(32'hF000_0000, 32'h0, 32'h0, 32'h0);
      wait_valid("b_latency");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rnd", 32'(rnd), 32'h3);
         check("hold_valid", 32'(rnd_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(4'h3);
      exp_q.push_back(4'h0);
      consume(2);

      // reseed colliding with rnd_ready: seed wins, LOAD count 1
      seed_in    = 32'h4000_0000;
      seed_valid = 1'b1;
      rnd_ready  = 1'b1;
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
      rnd_ready  = 1'b0;
      check("coll_rnd_valid", 32'(rnd_valid), 32'd0);
      check("coll_rnd", 32'(rnd), 32'd0);
      check("coll_state", 32'(fsm_state), 32'd1);
      send_word(32'h0);
      send_word(32'h0);
      send_word(32'h0);
      check("coll_warm_state", 32'(fsm_state), 32'd2);
      check("coll_warm_seed_ready", 32'(seed_ready), 32'd0);
      wait_valid("coll_latency");
      exp_q.push_back(4'h4);
      exp_q.push_back(4'h0);
      consume(2);

      // all-zero seed: guard loads S = 1, first rnd 0 with S = 0x10
      send_seed(32'h0, 32'h0, 32'h0, 32'h0);
      wait_valid("z_latency");
      exp_q.push_back(4'h0);
      exp_q.push_back(4'h0);
      consume(2);
      sb_en     = 1'b0;
      rnd_ready = 1'b1;
      zrun      = 0;
      zmax      = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rnd == '0) zrun++;
         else zrun = 0;
         if (zrun > zmax) zmax = zrun;
         @(posedge clk);
         #1;
      end
      rnd_ready = 1'b0;
      // 33 zero nibbles in a row would mean the whole 128-bit state is zero
      check("zero_guard_not_stuck", 32'(zmax < 33), 32'd1);
      check("zero_guard_valid", 32'(rnd_valid), 32'd1);
      sb_en = 1'b1;

      // reset mid-LOAD drops the partial seed
      send_word(32'h1234_5678);
      send_word(32'h0000_0009);
      check("midload_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midload_rst");
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_seed(32'hF000_0000, 32'h0, 32'h0, 32'h0);
      wait_valid("midload_latency");
      exp_q.push_back(4'h3);
      consume(1);

      // reset mid-WARMUP, then seed A reproduces 4, 0, 0
      send_seed(32'h4000_0000, 32'h0, 32'h0, 32'h0);
      check("midwarm_busy", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midwarm_rst");
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midwarm_after_state", 32'(fsm_state), 32'd0);
      check("midwarm_after_valid", 32'(rnd_valid), 32'd0);
      send_seed(32'h4000_0000, 32'h0, 32'h0, 32'h0);
      wait_valid("midwarm_latency");
      exp_q.push_back(4'h4);
      exp_q.push_back(4'h0);
      exp_q.push_back(4'h0);
      consume(3);

      // final report
      repeat (2) @(posedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/msk_rnd_source.md
MSK_RND_SOURCE -- requirements
Module: msk_rnd_source

Interface
REQ-001 Parameter: RND_W, default 4, width of the fresh-randomness bus delivered per cycle to masked gadgets; legal range 1..32.
REQ-002 Parameter: WARM, default 32, number of discard cycles after seeding; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seed_in  input  32  seed word.
REQ-006 seed_valid  input  1  seed_in valid.
REQ-007 seed_ready  output  1  block accepts a seed word this cycle.
REQ-008 rnd  output  RND_W  fresh randomness to gadget rnd ports.
REQ-009 rnd_valid  output  1  rnd carries fresh, not-yet-consumed bits.
REQ-010 rnd_ready  input  1  consumer takes rnd this cycle.
REQ-011 busy  output  1  high in LOAD or WARMUP.

Function
REQ-012 State: 128-bit register S plus FSM with states IDLE, LOAD, WARMUP, RUN; 2-bit word counter; 8-bit warmup counter.
REQ-013 LFSR step: fb = S[127]^S[125]^S[100]^S[98]; S <= {S[126:0], fb}; "advance" means RND_W consecutive steps in one cycle (unrolled combinationally).
REQ-014 Seed handshake: word accepted iff seed_valid & seed_ready; on accept S <= {S[95:0], seed_in}, so the first word ends in S[127:96].
REQ-015 seed_ready = 1 in IDLE, LOAD and RUN; 0 in WARMUP.
REQ-016 IDLE: on accept -> LOAD, word count = 1.
REQ-017 LOAD: each accept increments word count; the accept of word 4 -> WARMUP and loads the warmup counter with WARM; no accept -> hold S and count.
REQ-018 All-zero guard: if the shifted S after the 4th word equals 0, S SHALL instead be loaded with 128'h1 in that same cycle.
REQ-019 WARMUP: S advances every cycle, counter decrements; when counter reaches 0 after WARM advances -> RUN; seed_valid ignored.
REQ-020 RUN: rnd = S[RND_W-1:0], rnd_valid = 1; on rnd_valid & rnd_ready S advances once; otherwise S and rnd hold stable.
REQ-021 Reseed: a seed accept in RUN discards the current state as in REQ-014 -> LOAD with count = 1; rnd_valid drops in the same cycle (combinational on state) and no consumption is counted.
REQ-022 Simultaneous seed accept and rnd_ready in RUN: the seed accept wins; S is not advanced, only shifted with seed_in.
REQ-023 rnd_valid = 0 and rnd = 0 in IDLE, LOAD and WARMUP; rnd never exposes partially seeded state.
REQ-024 Latency: first rnd_valid appears exactly WARM cycles after the cycle that accepts word 4.
REQ-025 No path from seed_in or S to rnd other than registered S; rnd is a register slice only, glitch-free for gadget inputs.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, S = 0, both counters = 0, rnd_valid = 0, rnd = 0, busy = 0, seed_ready = 1.
REQ-027 Reset asserted mid-LOAD or mid-WARMUP discards all partial seed; no output is valid until 4 new words are loaded.

Verification
REQ-028 Reset then idle 10 cycles -> rnd_valid = 0, seed_ready = 1, busy = 0 throughout.
REQ-029 RND_W=4, WARM=1; seed words 0x40000000, 0, 0, 0 back-to-back -> busy for 1 cycle, then rnd_valid = 1, rnd = 4'h4; after one accept rnd = 4'h0 (S = 0x40).
REQ-030 Seed four zero words -> S = 1 after load; with WARM=1, RND_W=4 first rnd = 4'h0, S = 0x10; never stuck at all-zero over 1000 accepts.
REQ-031 In RUN hold rnd_ready = 0 for 5 cycles -> rnd stable and equal across all 5; one accept -> rnd changes per REQ-013.
REQ-032 In RUN assert seed_valid and rnd_ready in the same cycle -> rnd_valid = 0 next cycle, S not advanced, LOAD count = 1; reseed completes normally.
REQ-033 Pulse rst_n low during WARMUP -> all outputs at reset values asynchronously; following fresh seed reproduces the REQ-029 sequence exactly.
